// File: rtl/lsu_mc_if.sv
// Request/response/memory-bus bundle for the lsu_mc load/store unit.
// Every handshake here moves data on a cycle where valid=1 and ready=1; valid never waits for ready.
interface lsu_mc_if #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_op;
    logic [ADDR_W-1:0] req_addr;
    logic [XLEN-1:0]   req_wdata;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [XLEN-1:0]   rsp_rdata;
    logic              rsp_err;

    logic              mem_valid;
    logic              mem_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [XLEN-1:0]   mem_wdata;
    logic [XLEN/8-1:0] mem_wstrb;
    logic              mem_rvalid;
    logic [XLEN-1:0]   mem_rdata;

    modport slave (
        input  req_valid, req_we, req_op, req_addr, req_wdata,
        input  rsp_ready, mem_ready, mem_rvalid, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output mem_valid, mem_we, mem_addr, mem_wdata, mem_wstrb
    );

    modport master (
        output req_valid, req_we, req_op, req_addr, req_wdata,
        output rsp_ready, mem_ready, mem_rvalid, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  mem_valid, mem_we, mem_addr, mem_wdata, mem_wstrb
    );
endinterface

// File: rtl/lsu_mc.sv
// Multi-cycle load/store unit: one request at a time, lane steering to a word bus,
// load extension, alignment/legality checks and an optional read-data timeout.
module lsu_mc #(
    parameter int XLEN    = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 0
) (
    input  logic       clk,
    input  logic       rst,
    lsu_mc_if.slave    bus,
    output logic [1:0] dbg_state
);
    localparam int NB      = XLEN / 8;
    localparam int OFF_W   = $clog2(NB);
    localparam int CNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_REQ    = 2'd1;
    localparam logic [1:0] S_WAIT_R = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic [XLEN-1:0]   rdata_q, rdata_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [OFF_W-1:0]  req_off, req_amask;
    logic              req_illegal, req_bad;
    logic [OFF_W-1:0]  off;
    logic [OFF_W+2:0]  bit_off;
    logic [NB-1:0]     strb_base;
    logic [XLEN-1:0]   lane_rdata, lmask, load_data;
    logic              sbit, timeout_hit;

    // Decode of the incoming request, used only at acceptance.
    always_comb begin
        req_off     = bus.req_addr[OFF_W-1:0];
        req_amask   = OFF_W'((4'd1 << bus.req_op[1:0]) - 4'd1);
        req_illegal = (bus.req_op == 3'b111) || (bus.req_we && bus.req_op[2]) ||
                      ((XLEN == 32) && ((bus.req_op == 3'b011) || (bus.req_op == 3'b110)));
        req_bad     = req_illegal || (|(req_off & req_amask));
    end

    always_comb begin
        off     = addr_q[OFF_W-1:0];
        bit_off = {off, 3'b000};
        case (op_q[1:0])
            2'd0:    begin strb_base = NB'(1);       lmask = XLEN'(8'hFF);         end
            2'd1:    begin strb_base = NB'(2'b11);   lmask = XLEN'(16'hFFFF);      end
            2'd2:    begin strb_base = NB'(4'b1111); lmask = XLEN'(32'hFFFF_FFFF); end
            default: begin strb_base = '1;           lmask = '1;                   end
        endcase
        lane_rdata = bus.mem_rdata >> bit_off;
        case (op_q[1:0])
            2'd0:    sbit = lane_rdata[7];
            2'd1:    sbit = lane_rdata[15];
            2'd2:    sbit = lane_rdata[31];
            default: sbit = 1'b0;
        endcase
        // op[2] marks the unsigned loads; everything else sign-extends from the top loaded bit.
        load_data   = (lane_rdata & lmask) | ((sbit && !op_q[2]) ? ~lmask : '0);
        timeout_hit = (TIMEOUT > 0) && (cnt_q == CNT_W'(TO_LAST));
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    op_d    = bus.req_op;
                    we_d    = bus.req_we;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    rdata_d = '0;
                    err_d   = req_bad;
                    state_d = req_bad ? S_RESP : S_REQ;
                end
            end
            S_REQ: begin
                if (bus.mem_ready) begin
                    cnt_d   = '0;
                    state_d = we_q ? S_RESP : S_WAIT_R;
                end
            end
            S_WAIT_R: begin
                cnt_d = cnt_q + CNT_W'(1);
                // A timeout wins even when read data shows up on the same cycle.
                if (timeout_hit) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = S_RESP;
                end else if (bus.mem_rvalid) begin
                    rdata_d = load_data;
                    state_d = S_RESP;
                end
            end
            default: begin
                if (bus.rsp_ready) state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    // Bus fields come only from registered request state, so they cannot move while mem_valid=1.
    assign bus.req_ready = (state_q == S_IDLE);
    assign bus.mem_valid = (state_q == S_REQ);
    assign bus.mem_we    = (state_q == S_REQ) && we_q;
    assign bus.mem_addr  = (state_q == S_REQ) ? {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}} : '0;
    assign bus.mem_wdata = ((state_q == S_REQ) && we_q) ? (wdata_q << bit_off) : '0;
    assign bus.mem_wstrb = ((state_q == S_REQ) && we_q) ? (strb_base << off) : '0;
    assign bus.rsp_valid = (state_q == S_RESP);
    assign bus.rsp_rdata = (state_q == S_RESP) ? rdata_q : '0;
    assign bus.rsp_err   = (state_q == S_RESP) && err_q;
    assign dbg_state     = state_q;
endmodule

// File: tb/tb_lsu_mc.sv
// Randomized bench for lsu_mc (XLEN=32, TIMEOUT=8) against a transaction-level model.
module tb_lsu_mc;
    localparam int TO = 8;

    logic       clk;
    logic       rst;
    logic [1:0] dbg_state;
    int         checks;
    int         failures;

    lsu_mc_if #(.XLEN(32), .ADDR_W(32)) bus ();

    lsu_mc #(.XLEN(32), .ADDR_W(32), .TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // Expected per-cycle view, written by the driver just after each rising edge.
    logic        exp_req_ready, exp_mem_valid, exp_mem_we, exp_rsp_valid;
    logic [31:0] exp_mem_addr, exp_mem_wdata;
    logic [3:0]  exp_mem_wstrb;
    logic [32:0] exp_q[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic int op_size(input logic [2:0] op);
        return 1 << op[1:0];
    endfunction

    function automatic logic model_err(input logic we, input logic [2:0] op, input logic [31:0] addr);
        logic illegal;
        illegal = (op == 3'd7) || (we && op[2]) || (op == 3'd3) || (op == 3'd6);
        return illegal || ((addr % op_size(op)) != 0);
    endfunction

    function automatic logic [3:0] model_strb(input logic [2:0] op, input logic [31:0] addr);
        int v;
        v = ((1 << op_size(op)) - 1) << (addr % 4);
        return 4'(v);
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] op, input logic [31:0] addr,
                                                input logic [31:0] wdata);
        logic [63:0] m;
        m = (64'd1 << (8 * op_size(op))) - 64'd1;
        return 32'((64'(wdata) & m) << (8 * (addr % 4)));
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] op, input logic [31:0] addr,
                                               input logic [31:0] rdata);
        logic [63:0] m, v;
        m = (64'd1 << (8 * op_size(op))) - 64'd1;
        v = (64'(rdata) >> (8 * (addr % 4))) & m;
        if (!op[2] && v[8 * op_size(op) - 1]) v = v | ~m;
        return v[31:0];
    endfunction

    function automatic logic [31:0] bytemask(input logic [3:0] strb);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) r[8*b +: 8] = {8{strb[b]}};
        return r;
    endfunction

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        chk("req_ready", 64'(bus.req_ready), 64'(exp_req_ready));
        chk("mem_valid", 64'(bus.mem_valid), 64'(exp_mem_valid));
        chk("rsp_valid", 64'(bus.rsp_valid), 64'(exp_rsp_valid));
        if (exp_mem_valid) begin
            chk("mem_addr", 64'(bus.mem_addr), 64'(exp_mem_addr));
            chk("mem_we", 64'(bus.mem_we), 64'(exp_mem_we));
            chk("mem_wstrb", 64'(bus.mem_wstrb), 64'(exp_mem_wstrb));
            if (exp_mem_we)
                chk("mem_wdata", 64'(bus.mem_wdata & bytemask(exp_mem_wstrb)),
                    64'(exp_mem_wdata & bytemask(exp_mem_wstrb)));
        end
        if (bus.rsp_valid) begin
            if (exp_q.size() == 0) begin
                chk("rsp_unexpected", 64'({bus.rsp_err, bus.rsp_rdata}), 64'h1_DEAD_BEEF);
            end else begin
                chk("rsp_err_rdata", 64'({bus.rsp_err, bus.rsp_rdata}), 64'(exp_q[0]));
                if (bus.rsp_ready) void'(exp_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            bus.mem_rvalid = 1'($urandom);
            bus.mem_rdata  = $urandom;
            @(posedge clk); #1;
        end
        bus.mem_rvalid = 1'b0;
    endtask

    task automatic run_txn(input logic we, input logic [2:0] op, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] rdata,
                           input int rdy_dly, input int rv_dly, input int hold,
                           input int rst_at, input int exp_lat);
        logic        err;
        logic [32:0] word;
        int          lat;
        err  = model_err(we, op, addr);
        word = {1'b1, 32'h0};
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_op    = op;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'($urandom);
        bus.req_op    = 3'($urandom);
        bus.req_addr  = $urandom;
        bus.req_wdata = $urandom;
        exp_req_ready = 1'b0;
        lat = 1;
        if (!err) begin
            exp_mem_valid = 1'b1;
            exp_mem_we    = we;
            exp_mem_addr  = addr & 32'hFFFF_FFFC;
            exp_mem_wstrb = we ? model_strb(op, addr) : 4'h0;
            exp_mem_wdata = model_wdata(op, addr, wdata);
            for (int k = 0; k <= rdy_dly; k++) begin
                bus.mem_ready  = (k == rdy_dly);
                bus.mem_rvalid = 1'($urandom);
                bus.mem_rdata  = $urandom;
                @(posedge clk); #1;
                lat++;
            end
            bus.mem_ready  = 1'b0;
            bus.mem_rvalid = 1'b0;
            exp_mem_valid  = 1'b0;
            if (we) begin
                word = 33'h0;
            end else begin
                for (int i = 1; i <= TO; i++) begin
                    bus.mem_rvalid = (i - 1 == rv_dly);
                    bus.mem_rdata  = (i - 1 == rv_dly) ? rdata : $urandom;
                    if (i == rst_at) begin
                        rst = 1'b1;
                        exp_req_ready = 1'b1;
                        exp_rsp_valid = 1'b0;
                        #1;
                        chk("rst_abort_mem_valid", 64'(bus.mem_valid), 64'd0);
                        chk("rst_abort_rsp_valid", 64'(bus.rsp_valid), 64'd0);
                        chk("rst_abort_req_ready", 64'(bus.req_ready), 64'd1);
                        @(posedge clk); #1;
                        rst = 1'b0;
                        bus.mem_rvalid = 1'b1;
                        bus.mem_rdata  = rdata;
                        repeat (3) begin @(posedge clk); #1; end
                        bus.mem_rvalid = 1'b0;
                        return;
                    end
                    @(posedge clk); #1;
                    lat++;
                    if (i == TO) begin
                        word = {1'b1, 32'h0};
                        break;
                    end
                    if (bus.mem_rvalid) begin
                        word = {1'b0, model_load(op, addr, rdata)};
                        break;
                    end
                end
                bus.mem_rvalid = 1'b0;
            end
        end
        exp_q.push_back(word);
        exp_rsp_valid = 1'b1;
        if (exp_lat > 0) chk("latency_model", 64'(lat), 64'(exp_lat));
        for (int k = 0; k <= hold; k++) begin
            bus.rsp_ready  = (k == hold);
            bus.mem_rvalid = 1'($urandom);
            bus.mem_rdata  = $urandom;
            @(posedge clk); #1;
        end
        bus.rsp_ready  = 1'b0;
        bus.mem_rvalid = 1'b0;
        exp_rsp_valid  = 1'b0;
        exp_req_ready  = 1'b1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b0;
        exp_req_ready = 1'b1;
        exp_mem_valid = 1'b0;
        exp_mem_we    = 1'b0;
        exp_rsp_valid = 1'b0;
        exp_mem_addr  = 32'h0;
        exp_mem_wdata = 32'h0;
        exp_mem_wstrb = 4'h0;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_op    = 3'h0;
        bus.req_addr  = 32'h0;
        bus.req_wdata = 32'h0;
        bus.rsp_ready = 1'b0;
        bus.mem_ready = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata = 32'h0;
        #2 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_req_ready", 64'(bus.req_ready), 64'd1);
        chk("reset_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("reset_rsp_rdata", 64'(bus.rsp_rdata), 64'd0);
        chk("reset_rsp_err", 64'(bus.rsp_err), 64'd0);
        chk("reset_mem_valid", 64'(bus.mem_valid), 64'd0);
        chk("reset_mem_we", 64'(bus.mem_we), 64'd0);
        chk("reset_mem_addr", 64'(bus.mem_addr), 64'd0);
        chk("reset_mem_wdata", 64'(bus.mem_wdata), 64'd0);
        chk("reset_mem_wstrb", 64'(bus.mem_wstrb), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Hand-computed values pinning the model.
        chk("pin_lb_ext", 64'(model_load(3'b000, 32'h8000_0003, 32'h80AB_CD12)), 64'hFFFF_FF80);
        chk("pin_sh_strb", 64'(model_strb(3'b001, 32'h8000_0002)), 64'b1100);
        chk("pin_sh_wdata", 64'(model_wdata(3'b001, 32'h8000_0002, 32'h0000_BEEF)), 64'hBEEF_0000);
        chk("pin_lw_misaligned", 64'(model_err(1'b0, 3'b010, 32'h8000_0001)), 64'd1);
        chk("pin_lhu", 64'(model_load(3'b101, 32'h8000_0002, 32'hF00D_1234)), 64'h0000_F00D);
        chk("pin_lh", 64'(model_load(3'b001, 32'h8000_0002, 32'hF00D_1234)), 64'hFFFF_F00D);
        chk("pin_ld_illegal", 64'(model_err(1'b0, 3'b011, 32'h8000_0000)), 64'd1);

        // Directed scenarios.
        run_txn(1'b0, 3'b000, 32'h8000_0003, 32'h0, 32'h80AB_CD12, 0, 0, 0, 0, 3);
        run_txn(1'b1, 3'b001, 32'h8000_0002, 32'h0000_BEEF, 32'h0, 0, 0, 0, 0, 2);
        run_txn(1'b0, 3'b010, 32'h8000_0001, 32'h0, 32'h0, 0, 0, 0, 0, 1);
        run_txn(1'b0, 3'b010, 32'h8000_0004, 32'h0, 32'h1234_5678, 0, 50, 0, 0, 2 + TO);
        run_txn(1'b0, 3'b010, 32'h8000_0008, 32'h0, 32'h1234_5678, 0, TO - 1, 0, 0, 2 + TO);
        run_txn(1'b0, 3'b010, 32'h8000_000C, 32'h0, 32'hCAFE_F00D, 0, 50, 0, 3, 0);
        run_txn(1'b0, 3'b100, 32'h8000_0001, 32'h0, 32'h0000_9A00, 0, 0, 5, 0, 3);
        run_txn(1'b0, 3'b111, 32'h8000_0000, 32'h0, 32'h0, 0, 0, 1, 0, 1);
        run_txn(1'b1, 3'b100, 32'h8000_0000, 32'h55, 32'h0, 0, 0, 0, 0, 1);
        run_txn(1'b0, 3'b011, 32'h8000_0000, 32'h0, 32'h0, 0, 0, 0, 0, 1);
        run_txn(1'b0, 3'b110, 32'h8000_0000, 32'h0, 32'h0, 0, 0, 0, 0, 1);
        run_txn(1'b1, 3'b010, 32'h8000_0010, 32'hA5A5_5A5A, 32'h0, 3, 0, 2, 0, 5);

        // Randomized traffic.
        for (int n = 0; n < 250; n++) begin
            run_txn(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                    32'h8000_0000 | 32'($urandom_range(0, 255)), $urandom, $urandom,
                    $urandom_range(0, 3), $urandom_range(0, 9), $urandom_range(0, 3), 0, 0);
            idle_cycles($urandom_range(0, 2));
        end

        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/lsu_mc.md
LSU_MC -- requirements
Module: lsu_mc

Interface
REQ-001 Parameter XLEN, default 32, data width; legal values 32 and 64.
REQ-002 Parameter ADDR_W, default 32, byte-address width.
REQ-003 Parameter TIMEOUT, default 0, cycle limit for waiting on read data; 0 disables the timeout.
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 req_valid  in  1  request present.
REQ-007 req_ready  out  1  block can accept a request.
REQ-008 req_we  in  1  1=store, 0=load.
REQ-009 req_op  in  3  MemOp (funct3): 000 b, 001 h, 010 w, 011 d, 100 bu, 101 hu, 110 wu.
REQ-010 req_addr  in  ADDR_W  byte address.
REQ-011 req_wdata  in  XLEN  store data, LSB-justified.
REQ-012 rsp_valid  out  1  response present.
REQ-013 rsp_ready  in  1  consumer takes the response.
REQ-014 rsp_rdata  out  XLEN  load result after extension; 0 for stores and errors.
REQ-015 rsp_err  out  1  misaligned access, illegal op, or timeout.
REQ-016 mem_valid  out  1  bus request.
REQ-017 mem_ready  in  1  bus accepts the request.
REQ-018 mem_we  out  1  bus write.
REQ-019 mem_addr  out  ADDR_W  address aligned to XLEN/8 bytes.
REQ-020 mem_wdata  out  XLEN  store data shifted to the lane.
REQ-021 mem_wstrb  out  XLEN/8  byte enables; all 0 for reads.
REQ-022 mem_rvalid  in  1  read data valid.
REQ-023 mem_rdata  in  XLEN  full-word read data.

Function
REQ-024 The FSM SHALL have states IDLE, REQ, WAIT_R and RESP.
REQ-025 req_ready SHALL be 1 only in IDLE.
REQ-026 A request SHALL be accepted on a cycle with req_valid=1 in IDLE.
REQ-027 On acceptance, the block SHALL register op, we, addr and wdata.
REQ-028 The FSM SHALL go to REQ for a legal, aligned request.
REQ-029 The FSM SHALL go to RESP with rsp_err=1 and no bus activity for a misaligned or illegal request.
REQ-030 Ops 011 and 110 SHALL be illegal when XLEN=32.
REQ-031 Op 111 SHALL always be illegal.
REQ-032 Ops 1xx with req_we=1 SHALL be illegal.
REQ-033 A request is misaligned when the byte offset is not a multiple of the access size.
REQ-034 mem_valid SHALL equal 1 in REQ only.
REQ-035 mem_addr, mem_we, mem_wdata and mem_wstrb SHALL be stable while mem_valid=1.
REQ-036 In REQ with mem_ready=1: a store SHALL go to RESP; a load SHALL go to WAIT_R.
REQ-037 In WAIT_R with mem_rvalid=1, the block SHALL select the addressed lanes of mem_rdata into rsp_rdata and go to RESP.
REQ-038 Loaded data SHALL be sign-extended for b/h/w and zero-extended for bu/hu/wu.
REQ-039 When TIMEOUT>0, a counter SHALL clear on entry to WAIT_R.
REQ-040 The counter SHALL increment every WAIT_R cycle.
REQ-041 When the count reaches TIMEOUT, the FSM SHALL go to RESP with rsp_err=1 and rsp_rdata=0.
REQ-042 The timeout SHALL take priority over a mem_rvalid arriving in the same cycle.
REQ-043 rsp_valid SHALL be 1 in RESP only.
REQ-044 rsp_rdata and rsp_err SHALL hold stable until rsp_ready=1.
REQ-045 The handshake cycle (rsp_valid=1, rsp_ready=1) SHALL return the FSM to IDLE, so the next request can be accepted one cycle later.
REQ-046 mem_rvalid SHALL be ignored outside WAIT_R.
REQ-047 Minimum latency (acceptance to rsp_valid) SHALL be: load 3 cycles (mem_ready at once, mem_rvalid the next cycle), store 2 cycles, error 1 cycle.

Reset
REQ-048 While rst=1, the state SHALL be IDLE and every output SHALL be 0 except req_ready=1.
REQ-049 The timeout counter and registered request SHALL clear to 0 during reset.
REQ-050 Reset in any state SHALL abort the transaction immediately: mem_valid=0, no response, and data arriving after reset is ignored.

Verification
REQ-051 XLEN=32, lb at 0x80000003, mem_rdata=0x80ABCD12 -> rsp_rdata=0xFFFFFF80, rsp_err=0, rsp_valid 3 cycles after acceptance.
REQ-052 sh at 0x80000002, wdata 0x0000BEEF -> mem_addr=0x80000000, mem_wstrb=1100, mem_wdata=0xBEEF0000, rsp_valid 2 cycles after acceptance.
REQ-053 lw at 0x80000001 -> mem_valid stays 0; next cycle rsp_valid=1, rsp_err=1, rsp_rdata=0.
REQ-054 TIMEOUT=8, lw accepted by the bus, mem_rvalid never asserted -> rsp_err=1 after 8 WAIT_R cycles.
REQ-055 rst pulsed in WAIT_R, then mem_rvalid=1 -> mem_valid and rsp_valid drop at once, req_ready=1, no response is produced.
REQ-056 rsp_ready held at 0 for 5 cycles -> rsp_valid, rsp_rdata and rsp_err stay stable and req_ready=0 throughout.
